// File: rtl/cic_decimator.sv
// CIC / incremental decimator for 1-bit delta-sigma bitstreams, run-time ratio and mode.
// Define DECIM_BIPOLAR_EN to map x low to -1 and produce a two's complement z.
module cic_decimator #(
  parameter int ORDER       = 2,
  parameter int OUTPUT_BITS = 16,
  parameter int CNT_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   x,
  input  logic                   in_valid,
  input  logic                   mode,
  input  logic [CNT_BITS-1:0]    dec_ratio,
  input  logic                   conv_start,
  output logic [OUTPUT_BITS-1:0] z,
  output logic                   z_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_INC = 2'd1,
    ST_RUN_CIC = 2'd2
  } state_t;

  localparam logic [2:0] WARM_DONE = 3'(ORDER);

  state_t                 state_r;
  logic                   mode_r;
  logic [CNT_BITS-1:0]    ratio_r;
  logic [CNT_BITS-1:0]    cnt_r;
  logic [2:0]             warm_r;
  logic [OUTPUT_BITS-1:0] integ_r   [ORDER];
  logic [OUTPUT_BITS-1:0] comb_r    [ORDER];
  logic [OUTPUT_BITS-1:0] z_r;
  logic                   z_valid_r;
  logic                   busy_r;

  logic [OUTPUT_BITS-1:0] step_s;
  logic [OUTPUT_BITS-1:0] integ_upd_s [ORDER];
  logic [OUTPUT_BITS-1:0] comb_in_s   [ORDER];
  logic [OUTPUT_BITS-1:0] comb_last_s;
  logic                   mode_chg_s;
  logic                   clear_s;
  logic                   acc_s;
  logic                   last_s;
  logic                   cic_dump_s;

  // Sample weight of x
`ifdef DECIM_BIPOLAR_EN
  assign step_s = x ? OUTPUT_BITS'(1) : {OUTPUT_BITS{1'b1}};
`else
  assign step_s = {{(OUTPUT_BITS-1){1'b0}}, x};
`endif

  // Integrator chain and comb chain, both without inter-stage delay
  always_comb begin
    logic [OUTPUT_BITS-1:0] sum_s;
    sum_s = integ_r[0] + step_s;
    integ_upd_s[0] = sum_s;
    for (int i = 1; i < ORDER; i++) begin
      sum_s = integ_r[i] + sum_s;
      integ_upd_s[i] = sum_s;
    end
    for (int i = 0; i < ORDER; i++) begin
      comb_in_s[i] = sum_s;
      sum_s = sum_s - comb_r[i];
    end
    comb_last_s = sum_s;
  end

  // Control decode; a restart or mode change always wins over the sample
  always_comb begin
    mode_chg_s = (mode != mode_r);
    clear_s    = mode_chg_s
               || ((state_r == ST_IDLE) && conv_start && !mode)
               || ((state_r == ST_RUN_INC) && conv_start);
    acc_s      = !mode_chg_s && in_valid
               && (((state_r == ST_RUN_INC) && !conv_start) || (state_r == ST_RUN_CIC));
    last_s     = (cnt_r == ratio_r);
    cic_dump_s = acc_s && last_s && (state_r == ST_RUN_CIC);
  end

  // Datapath registers: integrators, comb delays, sample and warm-up counters
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_r[i] <= '0;
        comb_r[i]  <= '0;
      end
      cnt_r  <= '0;
      warm_r <= 3'd0;
    end else begin
      if (acc_s) begin
        for (int i = 0; i < ORDER; i++) integ_r[i] <= integ_upd_s[i];
        cnt_r <= last_s ? '0 : cnt_r + CNT_BITS'(1);
      end
      if (cic_dump_s) begin
        for (int i = 0; i < ORDER; i++) comb_r[i] <= comb_in_s[i];
        if (warm_r != WARM_DONE) warm_r <= warm_r + 3'd1;
      end
    end
  end

  // Mode/state FSM with registered z, z_valid and busy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mode_r    <= 1'b0;
      ratio_r   <= '0;
      z_r       <= '0;
      z_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (mode_chg_s) begin
      mode_r    <= mode;
      z_valid_r <= 1'b0;
      if (mode) begin
        state_r <= ST_RUN_CIC;
        ratio_r <= dec_ratio;
        busy_r  <= 1'b1;
      end else begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end
    end else begin
      z_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (conv_start && !mode) begin
            ratio_r <= dec_ratio;
            state_r <= ST_RUN_INC;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN_INC: begin
          if (conv_start) begin
            ratio_r <= dec_ratio;
          end else if (acc_s && last_s) begin
            z_r       <= integ_upd_s[ORDER-1];
            z_valid_r <= 1'b1;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end
        end
        ST_RUN_CIC: begin
          // The first ORDER results carry partial comb history and stay hidden
          if (cic_dump_s && (warm_r == WARM_DONE)) begin
            z_r       <= comb_last_s;
            z_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign z       = z_r;
  assign z_valid = z_valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: stimulus queues expected (value, cycle) pairs, monitors check them.
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        reset, x, in_valid, mode, mode0, conv_start, cs3, cs1;
  logic [7:0]  dec_ratio;
  logic [15:0] z2, z3, z1;
  logic        zv2, zv3, zv1, busy2, busy3, busy1;

  typedef struct {
    logic [15:0] v;
    int          c;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q1[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_decimator #(.ORDER(2), .OUTPUT_BITS(16), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .mode(mode),
    .dec_ratio(dec_ratio), .conv_start(conv_start), .z(z2), .z_valid(zv2), .busy(busy2));

  cic_decimator #(.ORDER(3), .OUTPUT_BITS(16), .CNT_BITS(8)) dut3 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .mode(mode0),
    .dec_ratio(dec_ratio), .conv_start(cs3), .z(z3), .z_valid(zv3), .busy(busy3));

  cic_decimator #(.ORDER(1), .OUTPUT_BITS(16), .CNT_BITS(8)) dut1 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .mode(mode0),
    .dec_ratio(dec_ratio), .conv_start(cs1), .z(z1), .z_valid(zv1), .busy(busy1));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: z_valid seen at cycle %0d with no result expected", name, cyc);
  endtask

  function automatic logic [15:0] xv(input logic b);
`ifdef DECIM_BIPOLAR_EN
    return b ? 16'd1 : 16'hFFFF;
`else
    return b ? 16'd1 : 16'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (zv2 === 1'b1) begin
      if (q2.size() == 0) unexpected("dut2 result");
      else begin
        e = q2.pop_front();
        chk("dut2 z", int'(z2), int'(e.v));
        chk("dut2 cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (zv3 === 1'b1) begin
      if (q3.size() == 0) unexpected("dut3 result");
      else begin
        e = q3.pop_front();
        chk("dut3 z", int'(z3), int'(e.v));
        chk("dut3 cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (zv1 === 1'b1) begin
      if (q1.size() == 0) unexpected("dut1 result");
      else begin
        e = q1.pop_front();
        chk("dut1 z", int'(z1), int'(e.v));
        chk("dut1 cycle", cyc, e.c);
      end
    end
  end

  initial begin
    int          s;
    int          alt_exp;
    logic [3:0]  pat;
    logic [15:0] neg16;
    pat = 4'b1101;
`ifdef DECIM_BIPOLAR_EN
    alt_exp = 0;
    neg16   = 16'hFFF0;
`else
    alt_exp = 128;
    neg16   = 16'h0000;
`endif
    reset = 1'b1; x = 1'b0; in_valid = 1'b0; mode = 1'b0; mode0 = 1'b0;
    conv_start = 1'b0; cs3 = 1'b0; cs1 = 1'b0; dec_ratio = 8'd15;
    step(); step();
    chk("reset z", int'(z2), 0);
    chk("reset z_valid", int'(zv2), 0);
    chk("reset busy", int'(busy2), 0);
    reset = 1'b0;
    step();

    // Incremental, 16 ones, ORDER 2 and 3 side by side
    conv_start = 1'b1; cs3 = 1'b1;
    step();
    s = cyc; conv_start = 1'b0; cs3 = 1'b0;
    chk("busy after start", int'(busy2), 1);
    q2.push_back('{16'd136, s + 16});
    q3.push_back('{16'd816, s + 16});
    x = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("busy before last sample", int'(busy2), 1);
      step();
    end
    chk("busy after result", int'(busy2), 0);
    in_valid = 1'b0;
    step(); step();

    // in_valid on every other cycle
    conv_start = 1'b1;
    step();
    s = cyc; conv_start = 1'b0;
    q2.push_back('{16'd136, s + 32});
    for (int i = 0; i < 32; i++) begin
      in_valid = (i % 2 == 1);
      x = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();

    // Restart after 8 samples; dec_ratio change after the latch is ignored
    conv_start = 1'b1;
    step();
    conv_start = 1'b0; x = 1'b1; in_valid = 1'b1;
    repeat (8) step();
    in_valid = 1'b0; conv_start = 1'b1;
    step();
    s = cyc; conv_start = 1'b0; dec_ratio = 8'd3;
    q2.push_back('{16'd136, s + 16});
    in_valid = 1'b1;
    repeat (16) step();
    in_valid = 1'b0; dec_ratio = 8'd15;
    step();

    // M=1: start with a simultaneous sample (dropped), then back-to-back conversions
    dec_ratio = 8'd0; conv_start = 1'b1; in_valid = 1'b1; x = 1'b1;
    step();
    s = cyc; conv_start = 1'b0; x = 1'b0;
    q2.push_back('{xv(1'b0), s + 1});
    step();
    for (int i = 0; i < 4; i++) begin
      conv_start = 1'b1; in_valid = 1'b0;
      step();
      s = cyc; conv_start = 1'b0; in_valid = 1'b1; x = pat[i];
      q2.push_back('{xv(pat[i]), s + 1});
      step();
    end
    in_valid = 1'b0; dec_ratio = 8'd15;
    step();

    // Reset in the middle of a conversion
    conv_start = 1'b1;
    step();
    conv_start = 1'b0; in_valid = 1'b1; x = 1'b1;
    repeat (5) step();
    chk("busy mid conversion", int'(busy2), 1);
    reset = 1'b1;
    step();
    chk("mid reset z", int'(z2), 0);
    chk("mid reset z_valid", int'(zv2), 0);
    chk("mid reset busy", int'(busy2), 0);
    reset = 1'b0; in_valid = 1'b0;
    step();

    // CIC, continuous ones: two blanked results, then 256
    mode = 1'b1; in_valid = 1'b1; x = 1'b1;
    step();
    s = cyc;
    chk("busy in cic", int'(busy2), 1);
    q2.push_back('{16'd256, s + 48});
    q2.push_back('{16'd256, s + 64});
    repeat (72) step();
    mode = 1'b0;
    step();
    chk("busy after cic exit", int'(busy2), 0);

    // CIC re-entry with alternating input; blanking must restart
    mode = 1'b1;
    step();
    s = cyc;
    q2.push_back('{16'(alt_exp), s + 48});
    q2.push_back('{16'(alt_exp), s + 64});
    for (int i = 0; i < 64; i++) begin
      x = (i % 2 == 0);
      step();
    end
    mode = 1'b0; in_valid = 1'b0;
    step(); step();

    // ORDER 1, sixteen zeros
    cs1 = 1'b1;
    step();
    s = cyc; cs1 = 1'b0;
    q1.push_back('{neg16, s + 16});
    x = 1'b0; in_valid = 1'b1;
    repeat (16) step();
    in_valid = 1'b0;
    step(); step();

    chk("dut2 results outstanding", q2.size(), 0);
    chk("dut3 results outstanding", q3.size(), 0);
    chk("dut1 results outstanding", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised CIC/incremental decimation filter for 1-bit delta-sigma modulator bitstreams. It generalises the fixed 2nd-order, M=16 decimator in three ways: order and output width are set by parameters, the decimation ratio is selectable at run time, and it adds a sample-valid input, an output-valid strobe and a comb warm-up blanking period. It sits between the modulator bitstream input and the output pin mux, and runs either as an incremental ADC back end or as a free-running CIC decimator.

## Interface
- ORDER, 2: number of integrator stages, and of comb stages in CIC mode; legal range 1..4.
- OUTPUT_BITS, 16: width of every integrator, comb register and z.
- CNT_BITS, 8: width of dec_ratio and the sample counter; maximum M = 2^CNT_BITS.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  modulator bit; contributes +1 when high, 0 when low (see Configuration).
- in_valid  input  1  x is accepted on a clk edge where in_valid=1 and the state is RUN_INC or RUN_CIC.
- mode  input  1  0 = incremental, 1 = free-running CIC.
- dec_ratio  input  CNT_BITS  M-1; latched on conversion start or on CIC entry.
- conv_start  input  1  incremental mode only; starts or restarts a conversion.
- z  output  OUTPUT_BITS  decimated result; holds until the next z_valid.
- z_valid  output  1  one-cycle strobe marking a new z.
- busy  output  1  high when state != IDLE.

## Operation
- States: IDLE, RUN_INC, RUN_CIC.
- Integrators: on each accepted sample, int[0] += x, then int[i] += int[i-1] for i=1..ORDER-1. Each stage uses the value of the previous stage already updated in the same cycle, so there is no inter-stage delay.
- Arithmetic: all integrator and comb arithmetic is modulo 2^OUTPUT_BITS with no saturation. Results are exact only if the full-scale output is below 2^OUTPUT_BITS (M^ORDER in CIC mode; C(M+ORDER-1, ORDER) in incremental mode).
- IDLE, mode=0: conv_start clears all integrators and the sample counter, latches dec_ratio and moves to RUN_INC.
- RUN_INC:
  - Each accepted sample increments the counter.
  - On the sample where counter == latched dec_ratio, z takes the updated int[ORDER-1], z_valid pulses and the state returns to IDLE.
- RUN_CIC:
  - Integrators run continuously on accepted samples.
  - Every M accepted samples, the updated int[ORDER-1] passes through ORDER comb stages, each out = in - previous in (differential delay 1), evaluated in the same cycle. z takes the last comb output, then the integrators keep running; they are not cleared.
  - A warm-up counter suppresses z_valid, and leaves z unchanged, for the first ORDER decimated results after CIC entry.
- Mode change (mode differs from its registered copy):
  - Clears integrators, combs, counters and warm-up; any pending result is discarded with no z_valid.
  - The next state is RUN_CIC if mode=1, otherwise IDLE.
  - dec_ratio is latched on CIC entry.
- Boundary cases:
  - conv_start during RUN_INC: restart; clear and relatch, no output.
  - conv_start while mode=1: ignored.
  - conv_start and in_valid in the same IDLE cycle: clear wins; the sample is not accepted.
  - dec_ratio=0 (M=1): every accepted sample produces a result.
  - Changes to dec_ratio mid-conversion: ignored until the next latch point.
  - reset overrides every other input.

## Timing
- Reset values: z=0, z_valid=0, busy=0, all internal registers 0, state IDLE, registered mode copy 0. If mode=1 after reset, the block enters RUN_CIC one cycle after reset deasserts, through the mode-change rule.
- Latency: z and z_valid update on the same edge that accepts the M-th sample; z_valid is high for exactly that following cycle.
- busy is high from the cycle after conv_start until the edge that produces z; it falls together with the z_valid rise.
- Throughput: one sample per clk; a new conversion may start in the cycle z_valid is high.

## Configuration
- DECIM_BIPOLAR_EN:
  - Defined: x maps to +1 (high) or -1 (low), and z is two's complement. Exact range requires full scale below 2^(OUTPUT_BITS-1).
  - Undefined: x maps to 1 or 0, and z is unsigned.
  - Both the state machine and the timing are identical in the two builds.

## Test plan
- Incremental, ORDER=2, dec_ratio=15, x=1 for 16 valid samples -> z=136, one z_valid pulse, busy then low; with ORDER=3 -> z=816.
- CIC, ORDER=2, dec_ratio=15, x=1 continuous -> first two results blanked, then z=256 with z_valid every 16 cycles; x alternating 1,0 -> z=128.
- in_valid low on every other cycle in incremental mode, 16 valid ones -> z=136, z_valid 32 cycles after start.
- conv_start pulsed again after 8 samples, then 16 ones -> only one z_valid with z=136; mode toggled mid-CIC -> no z_valid, and the blanking restarts.
- reset asserted during RUN_INC -> z=0, z_valid=0, busy=0 next cycle; dec_ratio=0 -> each sample outputs z=x.
- DECIM_BIPOLAR_EN, incremental ORDER=1, dec_ratio=15, x=0 for 16 samples -> z=0xFFF0 (-16).
